// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and frame constants for output_uart_tx (FRAME_BITS depends on UART_TX_PARITY_EN)
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int DEFAULT_CLKS_PER_BIT = 434;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, full/empty decoded from wrap-bit pointer compare
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   assign empty = wptr == rptr;
   assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rd_data = mem[rptr[AW-1:0]];
   always_ff @(posedge clock)
      if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
   always_ff @(posedge clock)
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en && !full) wptr <= wptr + (AW+1)'(1);
         if (rd_en && !empty) rptr <= rptr + (AW+1)'(1);
      end
endmodule

// File: rtl/output_uart_tx.sv
// output_uart_tx: buffers CPU output words and sends each as two UART bytes, high first; UART_TX_PARITY_EN adds even parity
module output_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] out_word,
   input  logic        out_valid,
   output logic        full,
   output logic        overflow,
   output logic        busy,
   output logic        tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] bitn;
   logic byte_idx;
   logic [15:0] sreg, head;
   logic empty, pop, bit_end;
`ifdef UART_TX_PARITY_EN
   logic par;
`endif
   assign pop = state == IDLE && !empty;
   assign busy = state != IDLE || !empty;
   assign bit_end = cnt == LAST;
   sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (out_valid),
      .wr_data(out_word),
      .rd_en  (pop),
      .rd_data(head),
      .full   (full),
      .empty  (empty)
   );
   // sreg holds {low byte, high byte} so the high byte shifts out first and the low byte is left in place
   always_ff @(posedge clock)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         bitn <= '0;
         byte_idx <= 1'b0;
         sreg <= '0;
         tx <= 1'b1;
         overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par <= 1'b0;
`endif
      end else begin
         if (out_valid && full) overflow <= 1'b1;
         cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
         case (state)
            IDLE: if (!empty) begin
               sreg <= {head[7:0], head[15:8]};
               byte_idx <= 1'b0;
               tx <= 1'b0;
               state <= START;
            end
            START: if (bit_end) begin
               bitn <= '0;
               tx <= sreg[0];
               sreg <= sreg >> 1;
`ifdef UART_TX_PARITY_EN
               par <= sreg[0];
`endif
               state <= DATA;
            end
            DATA: if (bit_end) begin
               if (bitn == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx <= par;
                  state <= PARITY;
`else
                  tx <= 1'b1;
                  state <= STOP;
`endif
               end else begin
                  bitn <= bitn + 3'd1;
                  tx <= sreg[0];
                  sreg <= sreg >> 1;
`ifdef UART_TX_PARITY_EN
                  par <= par ^ sreg[0];
`endif
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
               tx <= 1'b1;
               state <= STOP;
            end
`endif
            STOP: if (bit_end) begin
               tx <= !byte_idx ? 1'b0 : 1'b1;
               state <= !byte_idx ? START : IDLE;
               byte_idx <= 1'b1;
            end
            default: begin
               tx <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
endmodule
